// File: rtl/tm_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tm_pkg
//  Description : Shared defaults, index widths and helpers for the TM index
//                sequencer and its clause-output packer.
//  Revision    : 1.0 - initial release
// ============================================================================
package tm_pkg;

    // Default array geometry
    localparam int DEF_CLAUSES       = 2000;
    localparam int DEF_LA_CHUNKS     = 49;
    localparam int DEF_CLAUSE_CHUNKS = 63;

    // Index / address widths
    localparam int CLAUSE_ID_W   = 17;
    localparam int LA_CHUNK_W    = 17;
    localparam int CCHUNK_W      = 6;
    localparam int LA_ADDR_W     = 17;
    localparam int CBUF_WORD_W   = 32;
    localparam int CBUF_ADDR_W   = 6;
    localparam int PACK_IDX_W    = 5;

    // Integer ceiling division used for geometry consistency checks
    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tm_index_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : tm_index_sequencer_if
//  Description : Controller <-> index sequencer bundle: active-low phase
//                strobes in, indices / address / clause-buffer write out.
//  Revision    : 1.0 - initial release
// ============================================================================
interface tm_index_sequencer_if;
    import tm_pkg::*;

    logic                    reset_all;
    logic                    compare_states_ctrl;
    logic                    clause_out_ctrl;
    logic                    class_sum_ctrl;
    logic                    clause_out_bit;
    logic [CLAUSE_ID_W-1:0]  clause_id;
    logic [LA_CHUNK_W-1:0]   la_chunk_id;
    logic [CCHUNK_W-1:0]     clause_chunk_id;
    logic [LA_ADDR_W-1:0]    la_addr;
    logic                    cbuf_wr_en;
    logic [CBUF_ADDR_W-1:0]  cbuf_wr_addr;
    logic [CBUF_WORD_W-1:0]  cbuf_wr_data;
    logic                    scan_done;
    logic                    seq_err;

    // Controller side
    modport master (
        output reset_all, compare_states_ctrl, clause_out_ctrl,
               class_sum_ctrl, clause_out_bit,
        input  clause_id, la_chunk_id, clause_chunk_id, la_addr,
               cbuf_wr_en, cbuf_wr_addr, cbuf_wr_data, scan_done, seq_err
    );

    // Sequencer side
    modport slave (
        input  reset_all, compare_states_ctrl, clause_out_ctrl,
               class_sum_ctrl, clause_out_bit,
        output clause_id, la_chunk_id, clause_chunk_id, la_addr,
               cbuf_wr_en, cbuf_wr_addr, cbuf_wr_data, scan_done, seq_err
    );

endinterface
`default_nettype wire

// File: rtl/tm_clause_packer.sv
`default_nettype none
// ============================================================================
//  Module      : tm_clause_packer
//  Description : Collects one output bit per committed clause into a 32-bit
//                pack register and emits the completed word to the clause
//                buffer one cycle after the committing edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tm_clause_packer
    import tm_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_commit,
    input  logic                    i_bit,
    input  logic [PACK_IDX_W-1:0]   i_bit_idx,
    input  logic                    i_emit,
    input  logic [CBUF_ADDR_W-1:0]  i_word_addr,
    output logic                    o_wr_en,
    output logic [CBUF_ADDR_W-1:0]  o_wr_addr,
    output logic [CBUF_WORD_W-1:0]  o_wr_data
);

    logic [CBUF_WORD_W-1:0] pack_q, pack_d;
    logic [CBUF_WORD_W-1:0] w_pack_ins;
    logic                   wr_en_q, wr_en_d;
    logic [CBUF_ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [CBUF_WORD_W-1:0] wr_data_q, wr_data_d;

    // Insert the bit; on a word-closing commit hand the full word to the
    // write port and start the next word empty so stale bits never leak.
    always_comb begin
        w_pack_ins            = pack_q;
        w_pack_ins[i_bit_idx] = i_bit;
        pack_d                = pack_q;
        wr_en_d               = 1'b0;
        wr_addr_d             = wr_addr_q;
        wr_data_d             = wr_data_q;
        if (i_commit) begin
            if (i_emit) begin
                pack_d    = '0;
                wr_en_d   = 1'b1;
                wr_addr_d = i_word_addr;
                wr_data_d = w_pack_ins;
            end else begin
                pack_d    = w_pack_ins;
            end
        end
    end

    // Pack and write-port registers
    always_ff @(posedge clk) begin
        if (rst) begin
            pack_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            pack_q    <= pack_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign o_wr_en   = wr_en_q;
    assign o_wr_addr = wr_addr_q;
    assign o_wr_data = wr_data_q;

endmodule
`default_nettype wire

// File: rtl/tm_index_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tm_index_sequencer
//  Description : Iteration index / TA-address generator for the TM
//                controller. Advances on active-low phase strobes, keeps a
//                linear TA address by increment only, and packs clause
//                outputs into clause-buffer words.
//                Optional macro TM_SEQ_CHECK_EN enables the sticky seq_err
//                protocol checker; without it seq_err is tied low.
//  Revision    : 1.0 - initial release
// ============================================================================
module tm_index_sequencer
    import tm_pkg::*;
#(
    parameter int CLAUSES       = DEF_CLAUSES,
    parameter int LA_CHUNKS     = DEF_LA_CHUNKS,
    parameter int CLAUSE_CHUNKS = DEF_CLAUSE_CHUNKS
)(
    input  logic                 clk,
    input  logic                 rst_flag,
    tm_index_sequencer_if.slave  bus
);

    localparam logic [CLAUSE_ID_W-1:0] CLAUSE_LAST = CLAUSE_ID_W'(CLAUSES - 1);
    localparam logic [LA_CHUNK_W-1:0]  LA_LAST     = LA_CHUNK_W'(LA_CHUNKS - 1);
    localparam logic [CCHUNK_W-1:0]    CC_LAST     = CCHUNK_W'(CLAUSE_CHUNKS - 1);

    logic [CLAUSE_ID_W-1:0] clause_id_q, clause_id_d;
    logic [LA_CHUNK_W-1:0]  la_chunk_id_q, la_chunk_id_d;
    logic [CCHUNK_W-1:0]    clause_chunk_id_q, clause_chunk_id_d;
    logic [LA_ADDR_W-1:0]   la_addr_q, la_addr_d;
    logic                   scan_done_q, scan_done_d;

    logic w_rst;
    logic w_commit;
    logic w_la_adv;
    logic w_cs_adv;
    logic w_emit;

    assign w_rst    = rst_flag | bus.reset_all;
    // A commit after the final clause is dropped entirely
    assign w_commit = ~bus.clause_out_ctrl & ~scan_done_q;
    // Clause commit takes priority over LA advance in the same cycle
    assign w_la_adv = ~bus.compare_states_ctrl & bus.clause_out_ctrl;
    assign w_cs_adv = ~bus.class_sum_ctrl;
    // A word closes on its 32nd clause or on the final (possibly partial) one
    assign w_emit   = w_commit &
                      ((clause_id_q[4:0] == 5'd31) || (clause_id_q == CLAUSE_LAST));

    // Next-state for the counters and the linear TA address (saturating)
    always_comb begin
        clause_id_d       = clause_id_q;
        la_chunk_id_d     = la_chunk_id_q;
        clause_chunk_id_d = clause_chunk_id_q;
        la_addr_d         = la_addr_q;
        scan_done_d       = scan_done_q;
        if (w_commit) begin
            if (clause_id_q < CLAUSE_LAST) begin
                // Previous LA chunk was the last one, so +1 stays contiguous
                clause_id_d   = clause_id_q + 1'b1;
                la_chunk_id_d = '0;
                la_addr_d     = la_addr_q + 1'b1;
            end else begin
                scan_done_d   = 1'b1;
            end
        end else if (w_la_adv && (la_chunk_id_q < LA_LAST)) begin
            la_chunk_id_d = la_chunk_id_q + 1'b1;
            la_addr_d     = la_addr_q + 1'b1;
        end
        if (w_cs_adv && (clause_chunk_id_q < CC_LAST)) begin
            clause_chunk_id_d = clause_chunk_id_q + 1'b1;
        end
    end

    // Counter / address registers, cleared by either reset source
    always_ff @(posedge clk) begin
        if (w_rst) begin
            clause_id_q       <= '0;
            la_chunk_id_q     <= '0;
            clause_chunk_id_q <= '0;
            la_addr_q         <= '0;
            scan_done_q       <= 1'b0;
        end else begin
            clause_id_q       <= clause_id_d;
            la_chunk_id_q     <= la_chunk_id_d;
            clause_chunk_id_q <= clause_chunk_id_d;
            la_addr_q         <= la_addr_d;
            scan_done_q       <= scan_done_d;
        end
    end

    tm_clause_packer u_packer (
        .clk         (clk),
        .rst         (w_rst),
        .i_commit    (w_commit),
        .i_bit       (bus.clause_out_bit),
        .i_bit_idx   (clause_id_q[4:0]),
        .i_emit      (w_emit),
        .i_word_addr (clause_id_q[10:5]),
        .o_wr_en     (bus.cbuf_wr_en),
        .o_wr_addr   (bus.cbuf_wr_addr),
        .o_wr_data   (bus.cbuf_wr_data)
    );

`ifdef TM_SEQ_CHECK_EN
    localparam logic CFG_BAD = (CLAUSE_CHUNKS != ceil_div(CLAUSES, CBUF_WORD_W));

    logic seq_err_q, seq_err_d;

    // Sticky protocol-error accumulation
    always_comb begin
        seq_err_d = seq_err_q
                  | CFG_BAD
                  | (w_la_adv && (la_chunk_id_q == LA_LAST))
                  | (~bus.clause_out_ctrl & scan_done_q)
                  | (w_cs_adv && (clause_chunk_id_q == CC_LAST));
    end

    // Error flag register
    always_ff @(posedge clk) begin
        if (w_rst) begin
            seq_err_q <= 1'b0;
        end else begin
            seq_err_q <= seq_err_d;
        end
    end

    assign bus.seq_err = seq_err_q;
`else
    assign bus.seq_err = 1'b0;
`endif

    assign bus.clause_id       = clause_id_q;
    assign bus.la_chunk_id     = la_chunk_id_q;
    assign bus.clause_chunk_id = clause_chunk_id_q;
    assign bus.la_addr         = la_addr_q;
    assign bus.scan_done       = scan_done_q;

endmodule
`default_nettype wire

// File: tb/tb_tm_index_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tm_index_sequencer
//  Description : Directed self-checking bench for tm_index_sequencer. One
//                instance with default geometry, one with a 40-clause
//                geometry for the full scan. Honors TM_SEQ_CHECK_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tm_index_sequencer;

`ifdef TM_SEQ_CHECK_EN
    localparam logic CHK = 1'b1;
`else
    localparam logic CHK = 1'b0;
`endif

    logic clk;
    logic rst_flag;
    int   checks;
    int   errors;
    int   wr_cnt_a;
    int   wr_cnt_b;

    tm_index_sequencer_if ifa ();
    tm_index_sequencer_if ifb ();

    tm_index_sequencer dut_a (
        .clk      (clk),
        .rst_flag (rst_flag),
        .bus      (ifa.slave)
    );

    tm_index_sequencer #(
        .CLAUSES       (40),
        .LA_CHUNKS     (3),
        .CLAUSE_CHUNKS (2)
    ) dut_b (
        .clk      (clk),
        .rst_flag (rst_flag),
        .bus      (ifb.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count write strobes of each instance
    initial wr_cnt_a = 0;
    initial wr_cnt_b = 0;
    always @(negedge clk) begin
        if (ifa.cbuf_wr_en === 1'b1) wr_cnt_a = wr_cnt_a + 1;
        if (ifb.cbuf_wr_en === 1'b1) wr_cnt_b = wr_cnt_b + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_flag = 1'b1;
        tick();
        rst_flag = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({ifa.clause_id, ifa.la_chunk_id, ifa.clause_chunk_id, ifa.la_addr,
             ifa.cbuf_wr_en, ifa.cbuf_wr_addr, ifa.cbuf_wr_data, ifa.scan_done,
             ifa.seq_err} !== '0) begin
            errors++;
            $display("FAIL reset_init: clause_id=%0d la=%0d addr=%0d sd=%b err=%b required all 0",
                     ifa.clause_id, ifa.la_chunk_id, ifa.la_addr, ifa.scan_done, ifa.seq_err);
        end
        ifa.compare_states_ctrl = 1'b0;
        repeat (10) tick();
        checks++;
        if (ifa.la_chunk_id !== 17'd10 || ifa.la_addr !== 17'd10) begin
            errors++;
            $display("FAIL reset_prescan: la=%0d addr=%0d required 10/10",
                     ifa.la_chunk_id, ifa.la_addr);
        end
        rst_flag = 1'b1;
        tick();
        rst_flag = 1'b0;
        ifa.compare_states_ctrl = 1'b1;
        checks++;
        if ({ifa.clause_id, ifa.la_chunk_id, ifa.clause_chunk_id, ifa.la_addr,
             ifa.cbuf_wr_en, ifa.cbuf_wr_addr, ifa.cbuf_wr_data, ifa.scan_done,
             ifa.seq_err} !== '0) begin
            errors++;
            $display("FAIL reset_midscan: la=%0d addr=%0d required 0/0",
                     ifa.la_chunk_id, ifa.la_addr);
        end
        checks++;
        if (wr_cnt_a !== 0) begin
            errors++;
            $display("FAIL reset_no_write: wr pulses=%0d required 0", wr_cnt_a);
        end
    endtask

    task automatic test_la_sweep();
        do_reset();
        ifa.compare_states_ctrl = 1'b0;
        for (int i = 1; i <= 60; i++) begin
            tick();
            if (i == 47 || i == 48 || i == 49 || i == 60) begin
                checks++;
                if (ifa.la_chunk_id !== 17'((i < 48) ? i : 48) ||
                    ifa.la_addr !== 17'((i < 48) ? i : 48)) begin
                    errors++;
                    $display("FAIL la_sweep_c%0d: la=%0d addr=%0d required %0d",
                             i, ifa.la_chunk_id, ifa.la_addr, (i < 48) ? i : 48);
                end
            end
            if (i == 48 || i == 49) begin
                checks++;
                if (ifa.seq_err !== ((i == 49) ? CHK : 1'b0)) begin
                    errors++;
                    $display("FAIL la_sweep_err_c%0d: seq_err=%b required %b",
                             i, ifa.seq_err, (i == 49) ? CHK : 1'b0);
                end
            end
        end
        ifa.compare_states_ctrl = 1'b1;
    endtask

    task automatic test_overlap();
        ifa.clause_out_bit      = 1'b0;
        ifa.compare_states_ctrl = 1'b0;
        ifa.clause_out_ctrl     = 1'b0;
        tick();
        ifa.compare_states_ctrl = 1'b1;
        ifa.clause_out_ctrl     = 1'b1;
        checks++;
        if (ifa.clause_id !== 17'd1 || ifa.la_chunk_id !== 17'd0 ||
            ifa.la_addr !== 17'd49) begin
            errors++;
            $display("FAIL overlap: clause=%0d la=%0d addr=%0d required 1/0/49",
                     ifa.clause_id, ifa.la_chunk_id, ifa.la_addr);
        end
        checks++;
        if (ifa.cbuf_wr_en !== 1'b0) begin
            errors++;
            $display("FAIL overlap_wr: wr_en=%b required 0", ifa.cbuf_wr_en);
        end
    endtask

    task automatic test_class_sum();
        do_reset();
        ifa.class_sum_ctrl = 1'b0;
        for (int i = 1; i <= 70; i++) begin
            tick();
            if (i == 1 || i == 62 || i == 63 || i == 70) begin
                checks++;
                if (ifa.clause_chunk_id !== 6'((i < 62) ? i : 62)) begin
                    errors++;
                    $display("FAIL class_sum_c%0d: ccid=%0d required %0d",
                             i, ifa.clause_chunk_id, (i < 62) ? i : 62);
                end
            end
            if (i == 62 || i == 70) begin
                checks++;
                if (ifa.seq_err !== ((i == 70) ? CHK : 1'b0)) begin
                    errors++;
                    $display("FAIL class_sum_err_c%0d: seq_err=%b required %b",
                             i, ifa.seq_err, (i == 70) ? CHK : 1'b0);
                end
            end
        end
        ifa.class_sum_ctrl = 1'b1;
    endtask

    task automatic test_full_scan();
        int base;
        do_reset();
        base = wr_cnt_b;
        for (int c = 0; c < 40; c++) begin
            ifb.clause_out_bit      = c[0];
            ifb.compare_states_ctrl = 1'b0;
            tick();
            tick();
            if (c == 0 || c == 39) begin
                checks++;
                if (ifb.la_addr !== 17'(3 * c + 2) || ifb.la_chunk_id !== 17'd2) begin
                    errors++;
                    $display("FAIL scan_addr_c%0d: addr=%0d la=%0d required %0d/2",
                             c, ifb.la_addr, ifb.la_chunk_id, 3 * c + 2);
                end
            end
            ifb.clause_out_ctrl = 1'b0;
            tick();
            ifb.compare_states_ctrl = 1'b1;
            ifb.clause_out_ctrl     = 1'b1;
            checks++;
            if (c == 31) begin
                if (ifb.cbuf_wr_en !== 1'b1 || ifb.cbuf_wr_addr !== 6'd0 ||
                    ifb.cbuf_wr_data !== 32'hAAAA_AAAA) begin
                    errors++;
                    $display("FAIL scan_word0: en=%b addr=%0d data=%h required 1/0/aaaaaaaa",
                             ifb.cbuf_wr_en, ifb.cbuf_wr_addr, ifb.cbuf_wr_data);
                end
            end else if (c == 39) begin
                if (ifb.cbuf_wr_en !== 1'b1 || ifb.cbuf_wr_addr !== 6'd1 ||
                    ifb.cbuf_wr_data !== 32'h0000_00AA) begin
                    errors++;
                    $display("FAIL scan_word1: en=%b addr=%0d data=%h required 1/1/000000aa",
                             ifb.cbuf_wr_en, ifb.cbuf_wr_addr, ifb.cbuf_wr_data);
                end
            end else if (ifb.cbuf_wr_en !== 1'b0) begin
                errors++;
                $display("FAIL scan_nowr_c%0d: wr_en=%b required 0", c, ifb.cbuf_wr_en);
            end
        end
        tick();
        checks++;
        if (ifb.scan_done !== 1'b1 || ifb.clause_id !== 17'd39 || ifb.la_addr !== 17'd119) begin
            errors++;
            $display("FAIL scan_end: done=%b clause=%0d addr=%0d required 1/39/119",
                     ifb.scan_done, ifb.clause_id, ifb.la_addr);
        end
        checks++;
        if (wr_cnt_b - base !== 2 || ifb.cbuf_wr_en !== 1'b0) begin
            errors++;
            $display("FAIL scan_wr_count: pulses=%0d en=%b required 2/0",
                     wr_cnt_b - base, ifb.cbuf_wr_en);
        end
        checks++;
        if (ifb.seq_err !== 1'b0) begin
            errors++;
            $display("FAIL scan_err: seq_err=%b required 0", ifb.seq_err);
        end
    endtask

    task automatic test_commit_after_done();
        int base;
        base = wr_cnt_b;
        ifb.clause_out_bit  = 1'b1;
        ifb.clause_out_ctrl = 1'b0;
        tick();
        ifb.clause_out_ctrl = 1'b1;
        checks++;
        if (ifb.cbuf_wr_en !== 1'b0 || ifb.clause_id !== 17'd39 || ifb.la_addr !== 17'd119) begin
            errors++;
            $display("FAIL done_commit: en=%b clause=%0d addr=%0d required 0/39/119",
                     ifb.cbuf_wr_en, ifb.clause_id, ifb.la_addr);
        end
        checks++;
        if (ifb.seq_err !== CHK) begin
            errors++;
            $display("FAIL done_err: seq_err=%b required %b", ifb.seq_err, CHK);
        end
        tick();
        checks++;
        if (wr_cnt_b !== base) begin
            errors++;
            $display("FAIL done_no_write: pulses=%0d required 0", wr_cnt_b - base);
        end
    endtask

    task automatic test_reset_all();
        ifb.reset_all = 1'b1;
        tick();
        ifb.reset_all = 1'b0;
        checks++;
        if (ifb.scan_done !== 1'b0 || ifb.clause_id !== 17'd0 ||
            ifb.la_addr !== 17'd0 || ifb.seq_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_all: done=%b clause=%0d addr=%0d err=%b required all 0",
                     ifb.scan_done, ifb.clause_id, ifb.la_addr, ifb.seq_err);
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst_flag = 1'b0;
        ifa.reset_all = 1'b0; ifa.compare_states_ctrl = 1'b1; ifa.clause_out_ctrl = 1'b1;
        ifa.class_sum_ctrl = 1'b1; ifa.clause_out_bit = 1'b0;
        ifb.reset_all = 1'b0; ifb.compare_states_ctrl = 1'b1; ifb.clause_out_ctrl = 1'b1;
        ifb.class_sum_ctrl = 1'b1; ifb.clause_out_bit = 1'b0;
        test_reset();
        test_la_sweep();
        test_overlap();
        test_class_sum();
        test_full_scan();
        test_commit_after_done();
        test_reset_all();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
